// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, instruction field positions and
// the writeback bundle that the writeback stage, the register file and the
// operand fetch stage all agree on.
package core_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned RegAw = 5;

  // Register specifier fields inside a 32-bit instruction word.
  localparam int unsigned Rs1Lsb = 15;
  localparam int unsigned Rs1Msb = 19;
  localparam int unsigned Rs2Lsb = 20;
  localparam int unsigned Rs2Msb = 24;
  localparam int unsigned RdLsb  = 7;
  localparam int unsigned RdMsb  = 11;

  typedef logic [RegAw-1:0] reg_addr_t;

  typedef struct packed {
    logic            we;
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_t;

endpackage

// File: rtl/operand_bypass.sv
// Single-operand resolver. Picks the freshest value for register rs_i from
// two candidate writes and the register file read data.
//   rs_i      : source register specifier
//   cur_i     : write presented this cycle (highest priority)
//   last_i    : write presented last cycle (second priority)
//   rf_data_i : register file read data (fallback)
//   val_o     : resolved operand; x0 always reads as zero
module operand_bypass
  import core_pkg::*;
(
  input  reg_addr_t       rs_i,
  input  wb_t             cur_i,
  input  wb_t             last_i,
  input  logic [XLEN-1:0] rf_data_i,
  output logic [XLEN-1:0] val_o
);

  logic cur_hit;
  logic last_hit;

  assign cur_hit  = cur_i.we && (cur_i.rd == rs_i);
  assign last_hit = last_i.we && (last_i.rd == rs_i);

  always_comb begin
    if (rs_i == '0) begin
      val_o = '0;
    end else if (cur_hit) begin
      val_o = cur_i.data;
    end else if (last_hit) begin
      val_o = last_i.data;
    end else begin
      val_o = rf_data_i;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute.
// Two slots: S1 holds an instruction whose register file read is in flight,
// OUT holds an instruction with resolved operands for execute. Writebacks not
// yet visible in the file are bypassed into S1, and snooped into a stalled OUT.
//   clk, rst           : clock, synchronous active-high reset
//   flush              : drop everything in flight
//   in_*               : instruction from decode (valid/ready)
//   rf_rs1/2, rf_data* : register file read port (1-cycle read latency)
//   wb_*               : writeback port, shared with the register file
//   out_*              : instruction plus resolved operands to execute
module operand_fetch
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val
);

  wb_t wb_cur;
  wb_t lwb_q, lwb_d;

  logic            s1_valid_q, s1_valid_d;
  logic [ILEN-1:0] s1_instr_q, s1_instr_d;
  logic [XLEN-1:0] s1_pc_q, s1_pc_d;

  logic            out_valid_q, out_valid_d;
  logic [ILEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_rs1_val_q, out_rs1_val_d;
  logic [XLEN-1:0] out_rs2_val_q, out_rs2_val_d;

  logic out_fire;
  logic s1_adv;
  logic in_fire;

  logic [XLEN-1:0] s1_rs1_val, s1_rs2_val;
  logic [XLEN-1:0] snoop_rs1_val, snoop_rs2_val;

  assign wb_cur = '{we: wb_we, rd: wb_rd, data: wb_data};

  assign out_fire = out_valid_q & out_ready;
  assign s1_adv   = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~rst & ~flush & (~s1_valid_q | s1_adv);
  assign in_fire  = in_valid & in_ready;

  // A stalled S1 keeps re-reading so its file data tracks committed writes.
  always_comb begin
    if (rst) begin
      rf_rs1 = '0;
      rf_rs2 = '0;
    end else if (in_fire) begin
      rf_rs1 = in_instr[Rs1Msb:Rs1Lsb];
      rf_rs2 = in_instr[Rs2Msb:Rs2Lsb];
    end else begin
      rf_rs1 = s1_instr_q[Rs1Msb:Rs1Lsb];
      rf_rs2 = s1_instr_q[Rs2Msb:Rs2Lsb];
    end
  end

  // lwb covers the write that committed on the same edge the file sampled.
  operand_bypass u_s1_rs1 (
    .rs_i      (s1_instr_q[Rs1Msb:Rs1Lsb]),
    .cur_i     (wb_cur),
    .last_i    (lwb_q),
    .rf_data_i (rf_data1),
    .val_o     (s1_rs1_val)
  );

  operand_bypass u_s1_rs2 (
    .rs_i      (s1_instr_q[Rs2Msb:Rs2Lsb]),
    .cur_i     (wb_cur),
    .last_i    (lwb_q),
    .rf_data_i (rf_data2),
    .val_o     (s1_rs2_val)
  );

  // OUT snoop: only the live write matters, the held value is the fallback.
  operand_bypass u_out_rs1 (
    .rs_i      (out_instr_q[Rs1Msb:Rs1Lsb]),
    .cur_i     (wb_cur),
    .last_i    ('0),
    .rf_data_i (out_rs1_val_q),
    .val_o     (snoop_rs1_val)
  );

  operand_bypass u_out_rs2 (
    .rs_i      (out_instr_q[Rs2Msb:Rs2Lsb]),
    .cur_i     (wb_cur),
    .last_i    ('0),
    .rf_data_i (out_rs2_val_q),
    .val_o     (snoop_rs2_val)
  );

  always_comb begin
    lwb_d         = wb_cur;
    s1_valid_d    = s1_valid_q;
    s1_instr_d    = s1_instr_q;
    s1_pc_d       = s1_pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    out_rs1_val_d = out_rs1_val_q;
    out_rs2_val_d = out_rs2_val_q;

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_d = 1'b1;
        s1_instr_d = in_instr;
        s1_pc_d    = in_pc;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
        out_valid_d   = 1'b1;
        out_instr_d   = s1_instr_q;
        out_pc_d      = s1_pc_q;
        out_rs1_val_d = s1_rs1_val;
        out_rs2_val_d = s1_rs2_val;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end else if (out_valid_q) begin
        // Stalled in OUT: keep operands fresh against live writebacks.
        out_rs1_val_d = snoop_rs1_val;
        out_rs2_val_d = snoop_rs2_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lwb_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_instr_q    <= '0;
      s1_pc_q       <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      out_rs1_val_q <= '0;
      out_rs2_val_q <= '0;
    end else begin
      lwb_q         <= lwb_d;
      s1_valid_q    <= s1_valid_d;
      s1_instr_q    <= s1_instr_d;
      s1_pc_q       <= s1_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      out_rs1_val_q <= out_rs1_val_d;
      out_rs2_val_q <= out_rs2_val_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_rd      = out_instr_q[RdMsb:RdLsb];
  assign out_rs1_val = out_rs1_val_q;
  assign out_rs2_val = out_rs2_val_q;

endmodule
